clk_div_bank: RTL and testbench

- Multi-channel, runtime-programmable clock-enable and divided-clock generator with an integrated reset-release sequencer.
- Successor to the single fixed-ratio divider that produces one derived clock and one reset-ready flag.
- Sits at the top of the fabric clock tree: feeds slower subsystems with phase-aligned divided clocks and per-channel tick enables.
- Holds downstream logic in reset until the divided domains are stable.

---
 rtl/clk_div_bank.sv | 164 ++++++++++++++++
 tb/tb_clk_div_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of runtime-programmable clock dividers with a
// reset-release sequencer.
//
// Every channel produces a divided clock, clk_out (period 2*N, 50% duty),
// and a one-cycle tick every N cycles. All channels start together when rr
// falls, so they stay phase-aligned. A new divide value is held as pending
// and is copied to active only at the channel's wrap, so every period
// completes at the ratio it started with.
//
// Optional feature: define CLK_DIV_BANK_RESYNC_EN to add the resync input.
// A resync pulse realigns all channels and applies all pending values.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   resync    in   (CLK_DIV_BANK_RESYNC_EN only) realign all channels
//   en        in   global run enable; low freezes every channel
//   div_load  in   strobe: write div_val into the pending value of div_sel
//   div_sel   in   target channel for div_load
//   div_val   in   new divide value N (0 behaves as 1)
//   clk_out   out  divided clock per channel
//   tick      out  one-cycle pulse per channel, registered
//   rr        out  reset-release, high while downstream is held in reset
//   busy      out  channel has a pending value not yet applied
module clk_div_bank #(
  parameter  int NCH      = 4,
  parameter  int DIV_W    = 8,
  parameter  int RST_HOLD = 16,
  parameter  int DIV_INIT = 2,
  localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLK_DIV_BANK_RESYNC_EN
  input  logic             resync,
`endif
  input  logic             en,
  input  logic             div_load,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_val,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic             rr,
  output logic [NCH-1:0]   busy
);

  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DIV_INIT);

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } seq_state_t;

  seq_state_t state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

  logic [NCH-1:0][DIV_W-1:0] cnt;
  logic [NCH-1:0][DIV_W-1:0] act_div;
  logic [NCH-1:0][DIV_W-1:0] pend_div;
  logic [NCH-1:0][DIV_W-1:0] last_cnt;
  logic [NCH-1:0]            wrap;
  logic [NCH-1:0]            load_hit;
  logic                      run;
  logic                      do_resync;

  // Reset-release sequencer state register. The hold counter starts from
  // zero on every reset, so a reset at any time restarts the full hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Count RST_HOLD low-reset cycles, then release rr for good. rr is a
  // decode of the state register only, so it has no path from inputs.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    rr           = 1'b1;
    case (state)
      ST_HOLD: begin
        rr = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        rr = 1'b0;
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

`ifdef CLK_DIV_BANK_RESYNC_EN
  assign do_resync = resync & ~rr;
`else
  assign do_resync = 1'b0;
`endif

  // Per-channel wrap detection. A divide value of 0 counts as 1, so the
  // last count is 0 in both cases.
  always_comb begin
    run = ~rr & en;
    for (int i = 0; i < NCH; i++) begin
      last_cnt[i] = (act_div[i] == '0) ? '0 : act_div[i] - DIV_W'(1);
      wrap[i]     = run && (cnt[i] == last_cnt[i]);
      load_hit[i] = div_load && (int'(div_sel) == i);
    end
  end

  // Channel datapath. Pending takes writes at any time outside reset. A
  // write that lands on the wrap edge leaves busy set, because the wrap
  // applies the older pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= '0;
      tick    <= '0;
      busy    <= '0;
      for (int i = 0; i < NCH; i++) begin
        act_div[i]  <= DIV_RST;
        pend_div[i] <= DIV_RST;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load_hit[i]) begin
          pend_div[i] <= div_val;
        end
        if (do_resync) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          act_div[i] <= pend_div[i];
          busy[i]    <= load_hit[i];
        end else begin
          tick[i] <= wrap[i];
          if (wrap[i]) begin
            cnt[i]     <= '0;
            clk_out[i] <= ~clk_out[i];
            act_div[i] <= pend_div[i];
          end else if (run) begin
            cnt[i] <= cnt[i] + DIV_W'(1);
          end
          if (load_hit[i]) begin
            busy[i] <= 1'b1;
          end else if (wrap[i]) begin
            busy[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: self-checking bench for clk_div_bank.
// Behavioural model: each channel counts down the cycles left in its
// current period and reloads from the pending ratio when it reaches zero.
// rr is modelled as a count of low-reset cycles.
module tb_clk_div_bank;

  localparam int NCH      = 4;
  localparam int DIV_W    = 8;
  localparam int RST_HOLD = 16;
  localparam int DIV_INIT = 2;
  localparam int VW       = 1 + 3 * NCH;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_load;
  logic [1:0]       div_sel;
  logic [DIV_W-1:0] div_val;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic             rr;
  logic [NCH-1:0]   busy;
`ifdef CLK_DIV_BANK_RESYNC_EN
  logic             resync = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int             m_left[NCH];
  int             m_act[NCH];
  int             m_pend[NCH];
  logic [NCH-1:0] m_tick, m_clk, m_busy;
  logic           m_rr;
  int             m_low;

  typedef struct {
    int             cycles;
    logic           rst, en, ld;
    int             sel, val;
    logic           rr;
    logic [NCH-1:0] tick, clko, busy;
  } vec_t;

  vec_t tbl[14];

  clk_div_bank #(
    .NCH(NCH), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD), .DIV_INIT(DIV_INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef CLK_DIV_BANK_RESYNC_EN
    .resync(resync),
`endif
    .en(en),
    .div_load(div_load),
    .div_sel(div_sel),
    .div_val(div_val),
    .clk_out(clk_out),
    .tick(tick),
    .rr(rr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // One clock edge of the reference model, using the inputs seen at the edge.
  task automatic modelEdge();
    logic run;
    logic rsy;
    if (rst) begin
      m_rr  = 1'b1;
      m_low = 0;
      m_tick = '0;
      m_clk  = '0;
      m_busy = '0;
      for (int i = 0; i < NCH; i++) begin
        m_act[i]  = DIV_INIT;
        m_pend[i] = DIV_INIT;
        m_left[i] = eff(DIV_INIT);
      end
    end else begin
      run = !m_rr && en;
      rsy = 1'b0;
`ifdef CLK_DIV_BANK_RESYNC_EN
      rsy = resync && !m_rr;
`endif
      for (int i = 0; i < NCH; i++) begin
        if (rsy) begin
          m_act[i]  = m_pend[i];
          m_left[i] = eff(m_act[i]);
          m_clk[i]  = 1'b0;
          m_tick[i] = 1'b0;
          m_busy[i] = 1'b0;
        end else begin
          m_tick[i] = 1'b0;
          if (run) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
              m_tick[i] = 1'b1;
              m_clk[i]  = ~m_clk[i];
              m_act[i]  = m_pend[i];
              m_busy[i] = 1'b0;
              m_left[i] = eff(m_act[i]);
            end
          end
        end
        if (div_load && (int'(div_sel) == i)) begin
          m_pend[i] = int'(div_val);
          m_busy[i] = 1'b1;
        end
      end
      if (m_rr) begin
        m_low = m_low + 1;
        if (m_low >= RST_HOLD) m_rr = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, advance the model and compare every output.
  task automatic applyStimulus(input logic r, input logic e, input logic ld,
                               input int sel, input int val);
    rst      = r;
    en       = e;
    div_load = ld;
    div_sel  = 2'(sel);
    div_val  = DIV_W'(val);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("model", 32'({rr, tick, clk_out, busy}),
                32'({m_rr, m_tick, m_clk, m_busy}));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    int cnt_t[NCH];
    logic want;

    rst = 1'b1; en = 1'b1; div_load = 1'b0; div_sel = '0; div_val = '0;

    //                cyc rst en ld sel val  rr tick  clko  busy
    tbl[0]  = '{5,  1, 1, 0, 0, 0,  1, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{15, 0, 1, 0, 0, 0,  1, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1,  0, 1, 0, 0, 0,  0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1,  0, 1, 0, 0, 0,  0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{1,  0, 1, 0, 0, 0,  0, 4'hF, 4'hF, 4'h0};
    tbl[5]  = '{1,  0, 1, 0, 0, 0,  0, 4'h0, 4'hF, 4'h0};
    tbl[6]  = '{1,  0, 1, 0, 0, 0,  0, 4'hF, 4'h0, 4'h0};
    tbl[7]  = '{10, 0, 0, 0, 0, 0,  0, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{1,  0, 1, 0, 0, 0,  0, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{1,  0, 1, 0, 0, 0,  0, 4'hF, 4'hF, 4'h0};
    tbl[10] = '{1,  0, 1, 1, 1, 4,  0, 4'h0, 4'hF, 4'h2};
    tbl[11] = '{1,  0, 1, 0, 0, 0,  0, 4'hF, 4'h0, 4'h0};
    tbl[12] = '{1,  1, 1, 0, 0, 0,  1, 4'h0, 4'h0, 4'h0};
    tbl[13] = '{16, 0, 1, 0, 0, 0,  0, 4'h0, 4'h0, 4'h0};

    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < tbl[r].cycles; k++)
        applyStimulus(tbl[r].rst, tbl[r].en, tbl[r].ld, tbl[r].sel, tbl[r].val);
      checkOutput($sformatf("table row %0d", r), 32'({rr, tick, clk_out, busy}),
                  32'({tbl[r].rr, tbl[r].tick, tbl[r].clko, tbl[r].busy}));
    end

    // Mixed ratios loaded during the hold; the first period is still DIV_INIT.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 3, 0);
    idle(RST_HOLD - 4);
    for (int i = 0; i < NCH; i++) cnt_t[i] = 0;
    for (int e = 1; e <= 30; e++) begin
      idle(1);
      for (int i = 0; i < NCH; i++) cnt_t[i] += int'(tick[i]);
      if (e == 2) checkOutput("mixed first rise", 32'(clk_out), 32'hF);
    end
    checkOutput("mixed ticks ch0", cnt_t[0], 1 + (30 - DIV_INIT) / 1);
    checkOutput("mixed ticks ch1", cnt_t[1], 1 + (30 - DIV_INIT) / 3);
    checkOutput("mixed ticks ch2", cnt_t[2], 1 + (30 - DIV_INIT) / 5);
    checkOutput("mixed ticks ch3", cnt_t[3], 1 + (30 - DIV_INIT) / 1);

    // Glitch-free change: ch1 at N=4, load N=2 while its cnt is 1.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 4);
    idle(RST_HOLD - 1);
    for (int e = 1; e <= 15; e++) begin
      applyStimulus(1'b0, 1'b1, e == 8, 1, 2);
      want = (e == 2 || e == 6 || e == 10 || e == 12 || e == 14);
      checkOutput($sformatf("glitch tick1 e%0d", e), 32'(tick[1]), 32'(want));
      if (e >= 8 && e <= 10)
        checkOutput($sformatf("glitch busy1 e%0d", e), 32'(busy[1]), 32'(e != 10));
    end

    // Load ch2=7 exactly in the wrap cycle while pending=active=3.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 3);
    idle(RST_HOLD - 1);
    for (int e = 1; e <= 16; e++) begin
      applyStimulus(1'b0, 1'b1, e == 5, 2, 7);
      want = (e == 2 || e == 5 || e == 8 || e == 15);
      checkOutput($sformatf("wrapload tick2 e%0d", e), 32'(tick[2]), 32'(want));
      if (e >= 5 && e <= 8)
        checkOutput($sformatf("wrapload busy2 e%0d", e), 32'(busy[2]), 32'(e != 8));
    end

`ifdef CLK_DIV_BANK_RESYNC_EN
    // Channels at N=3 and N=5 mid-period, then a resync pulse.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 5);
    idle(RST_HOLD - 2);
    idle(9);
    resync = 1'b1;
    idle(1);
    resync = 1'b0;
    checkOutput("resync clk_out", 32'(clk_out[1:0]), 32'h0);
    checkOutput("resync tick", 32'(tick[1:0]), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      checkOutput($sformatf("resync tick0 k%0d", k), 32'(tick[0]), 32'(k == 3));
      checkOutput($sformatf("resync tick1 k%0d", k), 32'(tick[1]), 32'(k == 5));
    end
`endif

    // Randomized traffic against the model.
    doReset();
    for (int c = 0; c < 600; c++) begin
`ifdef CLK_DIV_BANK_RESYNC_EN
      resync = ($urandom_range(0, 39) == 0);
`endif
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 5) == 0, int'($urandom_range(0, NCH - 1)),
                    int'($urandom_range(0, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
